// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/writeback/flush bundle for the register-hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic             flush;
    logic             squash_valid;
    logic [4:0]       squash_rd;
    logic             squash_reg_write;
    logic             stall;
    logic             issue;
    logic [31:0]      pending;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write,
        output wb_valid, wb_rd, wb_reg_write,
        output flush, squash_valid, squash_rd, squash_reg_write,
        input  stall, issue, pending, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write,
        input  wb_valid, wb_rd, wb_reg_write,
        input  flush, squash_valid, squash_rd, squash_reg_write,
        output stall, issue, pending, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register in-flight write counters with RAW/WAW-overflow decode stall
module hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter int WB_BYPASS    = 1,
    parameter int CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb
);
    localparam logic [1:0] MAX_CNT = 2'(MAX_INFLIGHT);

    logic [1:0]       cnt_q [32];
    logic [1:0]       cnt_d [32];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic       inc, ret, sq;
    logic       ret_rs1, ret_rs2, ret_rd;
    logic [1:0] eff_rs1, eff_rs2;
    logic       raw, waw_full, stall, issue;
    logic       underflow;
    logic [2:0] up, dn, diff;

    always_comb begin
        ret     = sb.wb_valid && sb.wb_reg_write && (sb.wb_rd != 5'd0);
        sq      = sb.flush && sb.squash_valid && sb.squash_reg_write && (sb.squash_rd != 5'd0);
        ret_rs1 = ret && (sb.wb_rd == sb.id_rs1);
        ret_rs2 = ret && (sb.wb_rd == sb.id_rs2);
        ret_rd  = ret && (sb.wb_rd == sb.id_rd);
        // With bypass the register file is written before decode reads it, so a retiring write no longer counts.
        eff_rs1 = cnt_q[sb.id_rs1] - ((WB_BYPASS != 0) ? {1'b0, ret_rs1} : 2'd0);
        eff_rs2 = cnt_q[sb.id_rs2] - ((WB_BYPASS != 0) ? {1'b0, ret_rs2} : 2'd0);
        raw = (sb.id_rs1_used && (sb.id_rs1 != 5'd0) && (eff_rs1 != 2'd0))
           || (sb.id_rs2_used && (sb.id_rs2 != 5'd0) && (eff_rs2 != 2'd0));
        waw_full = sb.id_reg_write && (sb.id_rd != 5'd0)
                && (cnt_q[sb.id_rd] == MAX_CNT) && !ret_rd;
        stall = sb.id_valid && !sb.flush && (raw || waw_full);
        issue = sb.id_valid && !sb.flush && !stall;
        inc   = issue && sb.id_reg_write && (sb.id_rd != 5'd0);
    end

    always_comb begin
        underflow = 1'b0;
        up        = 3'd0;
        dn        = 3'd0;
        diff      = 3'd0;
        cnt_d[0]  = 2'd0;
        for (int r = 1; r < 32; r++) begin
            up   = {1'b0, cnt_q[r]} + {2'b00, inc && (sb.id_rd == 5'(r))};
            dn   = {2'b00, ret && (sb.wb_rd == 5'(r))} + {2'b00, sq && (sb.squash_rd == 5'(r))};
            diff = up - dn;
            if (dn > up) begin
                cnt_d[r]  = 2'd0;
                underflow = 1'b1;
            end else if (diff > 3'd3) begin
                cnt_d[r] = 2'd3;
            end else begin
                cnt_d[r] = diff[1:0];
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 2'd0;
            end
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        sb.pending = 32'd0;
        for (int r = 1; r < 32; r++) begin
            sb.pending[r] = (cnt_q[r] != 2'd0);
        end
    end

    assign sb.stall     = stall;
    assign sb.issue     = issue;
    assign sb.stall_cnt = stall_cnt_q;

    // Retiring or squashing a register with nothing in flight means the pipeline lost track of a write.
    underflow_chk: assert property (@(posedge clk) disable iff (rst) !underflow);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against an occupancy model
module tb_hazard_scoreboard;
    localparam int CNT_W        = 32;
    localparam int MAX_INFLIGHT = 3;
    localparam int WB_BYPASS    = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(CNT_W)) sb ();
    hazard_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT), .WB_BYPASS(WB_BYPASS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    int     cnt_m [32];
    longint stall_m;
    int     passed = 0;
    int     total  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit retiring(logic [4:0] r);
        return sb.wb_valid && sb.wb_reg_write && (sb.wb_rd != 5'd0) && (sb.wb_rd == r);
    endfunction

    function automatic bit busy(logic [4:0] r);
        int n;
        if (r == 5'd0) return 1'b0;
        n = cnt_m[r] - ((WB_BYPASS != 0 && retiring(r)) ? 1 : 0);
        return n != 0;
    endfunction

    function automatic bit exp_stall();
        bit raw, full;
        if (!sb.id_valid || sb.flush) return 1'b0;
        raw  = (sb.id_rs1_used && busy(sb.id_rs1)) || (sb.id_rs2_used && busy(sb.id_rs2));
        full = sb.id_reg_write && (sb.id_rd != 5'd0) && (cnt_m[sb.id_rd] >= MAX_INFLIGHT)
            && !retiring(sb.id_rd);
        return raw || full;
    endfunction

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = 32'd0;
        for (int r = 1; r < 32; r++) p[r] = (cnt_m[r] > 0);
        return p;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        stall_m = 0;
    endtask

    task automatic idle();
        sb.id_valid = 0; sb.id_rs1 = 0; sb.id_rs2 = 0; sb.id_rs1_used = 0; sb.id_rs2_used = 0;
        sb.id_rd = 0; sb.id_reg_write = 0;
        sb.wb_valid = 0; sb.wb_rd = 0; sb.wb_reg_write = 0;
        sb.flush = 0; sb.squash_valid = 0; sb.squash_rd = 0; sb.squash_reg_write = 0;
    endtask

    task automatic dec(logic [4:0] rs1, logic [4:0] rs2, bit u1, bit u2, logic [4:0] rd, bit rw);
        sb.id_valid = 1; sb.id_rs1 = rs1; sb.id_rs2 = rs2;
        sb.id_rs1_used = u1; sb.id_rs2_used = u2; sb.id_rd = rd; sb.id_reg_write = rw;
    endtask

    task automatic wb(logic [4:0] rd);
        sb.wb_valid = 1; sb.wb_rd = rd; sb.wb_reg_write = 1;
    endtask

    // One clock: check combinational gating before the edge, then state after it.
    task automatic cycle(string tag);
        bit es, ei;
        #1;
        es = exp_stall();
        ei = sb.id_valid && !sb.flush && !es;
        chk({tag, "_stall"}, 32'(sb.stall), 32'(es));
        chk({tag, "_issue"}, 32'(sb.issue), 32'(ei));
        @(posedge clk);
        if (ei && sb.id_reg_write && sb.id_rd != 5'd0) cnt_m[sb.id_rd]++;
        if (retiring(sb.wb_rd)) cnt_m[sb.wb_rd]--;
        if (sb.flush && sb.squash_valid && sb.squash_reg_write && sb.squash_rd != 5'd0)
            cnt_m[sb.squash_rd]--;
        for (int r = 0; r < 32; r++) if (cnt_m[r] < 0) cnt_m[r] = 0;
        if (es && stall_m < 64'hFFFF_FFFF) stall_m++;
        @(negedge clk);
        chk({tag, "_pending"}, sb.pending, exp_pending());
        chk({tag, "_stall_cnt"}, sb.stall_cnt, 32'(stall_m));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_pending", sb.pending, 32'd0);
        chk("reset_stall_cnt", sb.stall_cnt, 32'd0);

        idle(); dec(1, 2, 1, 1, 5, 1);
        #1 chk("add_issue", 32'(sb.issue), 32'd1);
        cycle("add");
        chk("add_pend", sb.pending, 32'h0000_0020);

        idle(); dec(5, 0, 1, 0, 6, 1);
        #1 chk("raw_hold_stall", 32'(sb.stall), 32'd1);
        cycle("raw_hold0");
        cycle("raw_hold1");
        chk("raw_hold_cnt", sb.stall_cnt, 32'd2);
        wb(5);
        #1 chk("raw_rel_issue", 32'(sb.issue), 32'd1);
        cycle("raw_rel");
        chk("raw_rel_pend", sb.pending, 32'h0000_0040);
        chk("raw_rel_cnt", sb.stall_cnt, 32'd2);

        idle(); dec(0, 0, 1, 1, 0, 1);
        cycle("x0");
        chk("x0_pend", sb.pending, 32'h0000_0040);

        idle(); dec(0, 0, 0, 0, 7, 1);
        cycle("sim_set");
        idle(); dec(0, 0, 0, 0, 7, 1); wb(7);
        cycle("sim_both");
        chk("sim_pend7", 32'(sb.pending[7]), 32'd1);

        idle(); dec(0, 0, 0, 0, 9, 1);
        cycle("sq_set");
        idle(); dec(9, 0, 1, 0, 10, 1);
        sb.flush = 1; sb.squash_valid = 1; sb.squash_rd = 9; sb.squash_reg_write = 1;
        #1 chk("sq_flush_issue", 32'(sb.issue), 32'd0);
        cycle("sq_flush");
        chk("sq_pend9", 32'(sb.pending[9]), 32'd0);
        idle(); dec(9, 9, 1, 1, 0, 0);
        cycle("sq_read");

        for (int i = 0; i < 3; i++) begin
            idle(); dec(0, 0, 0, 0, 3, 1);
            cycle("sat_fill");
        end
        idle(); dec(0, 0, 0, 0, 3, 1);
        #1 chk("sat_full_stall", 32'(sb.stall), 32'd1);
        cycle("sat_full");
        wb(3);
        #1 chk("sat_ret_issue", 32'(sb.issue), 32'd1);
        cycle("sat_ret");
        for (int i = 0; i < 3; i++) begin
            idle(); wb(3);
            cycle("sat_drain");
        end
        chk("sat_drained", 32'(sb.pending[3]), 32'd0);
        chk("dir_stall_cnt", sb.stall_cnt, 32'd3);

        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midrst_pending", sb.pending, 32'd0);
        chk("midrst_stall_cnt", sb.stall_cnt, 32'd0);

        for (int i = 0; i < 400; i++) begin
            idle();
            sb.id_valid     = ($urandom_range(0, 3) != 0);
            sb.id_rs1       = 5'($urandom_range(0, 7));
            sb.id_rs2       = 5'($urandom_range(0, 7));
            sb.id_rs1_used  = 1'($urandom_range(0, 1));
            sb.id_rs2_used  = 1'($urandom_range(0, 1));
            sb.id_rd        = 5'($urandom_range(0, 7));
            sb.id_reg_write = ($urandom_range(0, 3) != 0);
            sb.wb_valid     = 1'($urandom_range(0, 1));
            sb.wb_rd        = 5'($urandom_range(0, 7));
            sb.wb_reg_write = 1'($urandom_range(0, 1));
            sb.flush            = ($urandom_range(0, 7) == 0);
            sb.squash_valid     = 1'($urandom_range(0, 1));
            sb.squash_rd        = 5'($urandom_range(0, 7));
            sb.squash_reg_write = 1'($urandom_range(0, 1));
            if (retiring(sb.wb_rd) && cnt_m[sb.wb_rd] == 0) sb.wb_reg_write = 0;
            if (sb.flush && sb.squash_valid && sb.squash_reg_write && sb.squash_rd != 5'd0
                && (cnt_m[sb.squash_rd] - (retiring(sb.squash_rd) ? 1 : 0)) < 1)
                sb.squash_reg_write = 0;
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
